// File: rtl/lfu_led_tracker.sv
// Five-item LFU residency tracker driving one LED per item, updated once per
// prescaled tick; timed_clk is the exported tick square wave.

module lfu_slot #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ins,
  input  logic             i_hit,
  input  logic             i_evict,
  output logic             o_res,
  output logic [CNT_W-1:0] o_cnt
);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             r_res;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res <= 1'b0;
      r_cnt <= '0;
    end else if (i_evict) begin
      r_res <= 1'b0;
      r_cnt <= '0;
    end else if (i_ins) begin
      r_res <= 1'b1;
      r_cnt <= CNT_W'(1);
    end else if (i_hit && (r_cnt != CMAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_res = r_res;
  assign o_cnt = r_cnt;
endmodule

module lfu_led_tracker #(
  parameter int TICK_DIV = 8,
  parameter int CNT_W    = 4,
  parameter int CAPACITY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic b4,
  input  logic b5,
  output logic l1,
  output logic l2,
  output logic l3,
  output logic l4,
  output logic l5,
  output logic timed_clk
);
  localparam int NUM_ITEMS = 5;
  localparam int IDX_W     = 3;
  localparam int PC_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HALF      = TICK_DIV / 2;

  logic [PC_W-1:0] r_pcnt;
  logic [PC_W-1:0] w_pcnt_nxt;
  logic            r_tclk;
  logic            w_tick;

  assign w_pcnt_nxt = (r_pcnt == PC_W'(TICK_DIV - 1)) ? '0 : r_pcnt + PC_W'(1);
  // The tick edge is the one that raises timed_clk.
  assign w_tick     = (w_pcnt_nxt == PC_W'(HALF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
      r_tclk <= 1'b0;
    end else begin
      r_pcnt <= w_pcnt_nxt;
      r_tclk <= (w_pcnt_nxt >= PC_W'(HALF));
    end
  end

  assign timed_clk = r_tclk;

  logic [NUM_ITEMS-1:0]            w_btn;
  logic [NUM_ITEMS-1:0]            w_res;
  logic [NUM_ITEMS-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_ITEMS-1:0]            w_ins;
  logic [NUM_ITEMS-1:0]            w_hit;
  logic [NUM_ITEMS-1:0]            w_evict;

  assign w_btn = {b5, b4, b3, b2, b1};

  logic             w_req_vld;
  logic [IDX_W-1:0] w_req_idx;
  logic [IDX_W-1:0] w_occ;
  logic             w_full;
  logic             w_vic_vld;
  logic [IDX_W-1:0] w_vic_idx;
  logic [CNT_W-1:0] w_vic_cnt;
  logic             w_req_res;

  // Descending scan so the lowest-numbered button wins.
  always_comb begin
    w_req_vld = 1'b0;
    w_req_idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (w_btn[i]) begin
        w_req_vld = 1'b1;
        w_req_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      w_occ = w_occ + IDX_W'(w_res[i]);
    end
  end

  assign w_full    = (w_occ >= IDX_W'(CAPACITY));
  assign w_req_res = w_res[w_req_idx];

  // Strict less-than keeps the lowest index on count ties. The requested item
  // is non-resident on a miss, so it can never be picked here.
  always_comb begin
    w_vic_vld = 1'b0;
    w_vic_idx = '0;
    w_vic_cnt = '1;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (w_res[i] && (!w_vic_vld || (w_cnt[i] < w_vic_cnt))) begin
        w_vic_vld = 1'b1;
        w_vic_idx = IDX_W'(i);
        w_vic_cnt = w_cnt[i];
      end
    end
  end

  logic w_act;
  logic w_miss;
  logic w_do_evict;

  assign w_act      = w_tick && w_req_vld;
  assign w_miss     = w_act && !w_req_res;
  assign w_do_evict = w_miss && w_full && w_vic_vld;

  genvar g;
  generate
    for (g = 0; g < NUM_ITEMS; g++) begin : g_slot
      assign w_hit[g]   = w_act && w_req_res && (w_req_idx == IDX_W'(g));
      assign w_ins[g]   = w_miss && (w_req_idx == IDX_W'(g)) && (!w_full || w_vic_vld);
      assign w_evict[g] = w_do_evict && (w_vic_idx == IDX_W'(g));

      lfu_slot #(.CNT_W(CNT_W)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_ins   (w_ins[g]),
        .i_hit   (w_hit[g]),
        .i_evict (w_evict[g]),
        .o_res   (w_res[g]),
        .o_cnt   (w_cnt[g])
      );
    end
  endgenerate

  assign l1 = w_res[0];
  assign l2 = w_res[1];
  assign l3 = w_res[2];
  assign l4 = w_res[3];
  assign l5 = w_res[4];
endmodule

// File: tb/tb_lfu_led_tracker.sv
// Scoreboard bench for lfu_led_tracker: a behavioural LFU model queues the
// expected LED pattern per tick; it is popped and compared after each tick.

module tb_lfu_led_tracker;
  localparam int TICK_DIV = 8;
  localparam int CNT_W    = 4;
  localparam int CAPACITY = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, b4 = 1'b0, b5 = 1'b0;
  logic l1, l2, l3, l4, l5, timed_clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  int m_res[5];
  int m_cnt[5];

  always #5 clk = ~clk;

  lfu_led_tracker #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .CAPACITY(CAPACITY)) dut (
    .clk(clk), .rst(rst),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
    .l1(l1), .l2(l2), .l3(l3), .l4(l4), .l5(l5),
    .timed_clk(timed_clk)
  );

  // Vectors are written b1/l1 first (bit 4) to match the "10000" notation.
  function automatic logic [4:0] leds();
    return {l1, l2, l3, l4, l5};
  endfunction

  function automatic logic [4:0] model_leds();
    logic [4:0] e;
    e = '0;
    for (int i = 0; i < 5; i++) e[4-i] = (m_res[i] != 0);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_res[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input logic [4:0] btn);
    int k;
    int occ;
    int v;
    k = -1;
    for (int i = 0; i < 5; i++) if (btn[4-i] && k < 0) k = i;
    if (k < 0) return;
    if (m_res[k] != 0) begin
      if (m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
      return;
    end
    occ = 0;
    for (int i = 0; i < 5; i++) occ += m_res[i];
    if (occ >= CAPACITY) begin
      v = -1;
      for (int i = 0; i < 5; i++)
        if (m_res[i] != 0 && (v < 0 || m_cnt[i] < m_cnt[v])) v = i;
      m_res[v] = 0;
      m_cnt[v] = 0;
    end
    m_res[k] = 1;
    m_cnt[k] = 1;
  endtask

  // Present btn, wait for the next timed_clk rise, then score the LEDs.
  task automatic do_tick(input logic [4:0] btn, input string name);
    logic prev;
    logic got;
    logic [4:0] exp_v;
    model_step(btn);
    exp_q.push_back(model_leds());
    {b1, b2, b3, b4, b5} = btn;
    prev = timed_clk;
    got  = 1'b0;
    for (int c = 0; c < 2 * TICK_DIV + 2; c++) begin
      @(posedge clk);
      #1;
      if (timed_clk && !prev) begin
        got = 1'b1;
        break;
      end
      prev = timed_clk;
    end
    {b1, b2, b3, b4, b5} = '0;
    exp_v = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s tick_timeout: no timed_clk rise within %0d cycles", name, 2 * TICK_DIV + 2);
    end else if (leds() !== exp_v) begin
      errors++;
      $display("FAIL %s leds: got %b expected %b", name, leds(), exp_v);
    end
  endtask

  task automatic check_leds(input logic [4:0] exp_v, input string name);
    checks++;
    if (leds() !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, leds(), exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_leds(5'b00000, "reset_leds");
    checks++;
    if (timed_clk !== 1'b0) begin
      errors++;
      $display("FAIL reset_tclk: got %b expected 0", timed_clk);
    end
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (timed_clk !== 1'b1 && n < 4 * TICK_DIV) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != TICK_DIV / 2) begin
      errors++;
      $display("FAIL first_tick_latency: got %0d cycles expected %0d", n, TICK_DIV / 2);
    end
  endtask

  task automatic test_fill_hit_evict();
    do_reset();
    repeat (3) do_tick(5'b10000, "fill_b1");
    check_leds(5'b10000, "fill_grp1");
    repeat (3) do_tick(5'b01000, "fill_b2");
    check_leds(5'b11000, "fill_grp2");
    repeat (3) do_tick(5'b00100, "fill_b3");
    check_leds(5'b11100, "fill_grp3");
    repeat (2) do_tick(5'b00010, "fill_b4");
    check_leds(5'b11110, "fill_grp4");
    do_tick(5'b00001, "evict_b5");
    check_leds(5'b11101, "evict_min");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_leds(5'b00000, "async_rst_leds");
    checks++;
    if (timed_clk !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_tclk: got %b expected 0", timed_clk);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_tie_reinsert();
    do_reset();
    do_tick(5'b10000, "tie_b1");
    do_tick(5'b01000, "tie_b2");
    do_tick(5'b00100, "tie_b3");
    do_tick(5'b00010, "tie_b4");
    do_tick(5'b00001, "tie_b5");
    check_leds(5'b01111, "tie_evict_low");
    do_tick(5'b10000, "reins_b1");
    check_leds(5'b10111, "reinsert_b1");
  endtask

  task automatic test_priority_idle();
    do_reset();
    do_tick(5'b01010, "prio_b2b4");
    check_leds(5'b01000, "prio_lowest");
    repeat (5) do_tick(5'b00000, "idle");
    check_leds(5'b01000, "idle_hold");
  endtask

  // 16 hits would wrap a non-saturating counter to 0 and make b1 the victim.
  task automatic test_saturation();
    do_reset();
    repeat (CMAX + 1) do_tick(5'b10000, "sat_b1");
    do_tick(5'b01000, "sat_b2");
    do_tick(5'b00100, "sat_b3");
    do_tick(5'b00010, "sat_b4");
    do_tick(5'b00001, "sat_b5");
    check_leds(5'b10111, "sat_keep_b1");
  endtask

  task automatic test_random();
    logic [4:0] btn;
    int pc;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      btn = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) btn = 5'(1 << $urandom_range(0, 4));
      do_tick(btn, "random");
      pc = $countones(leds());
      checks++;
      if (pc > CAPACITY) begin
        errors++;
        $display("FAIL capacity: got %0d resident expected <= %0d", pc, CAPACITY);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_hit_evict();
    test_async_reset();
    test_tie_reinsert();
    test_priority_idle();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
